// File: rtl/mac_accumulator.sv
// Dot-product accumulator that sums multiplier products into one registered result per vector.
// Define MAC_SAT_EN to clamp the running sum on overflow instead of wrapping.
module mac_accumulator #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p_valid,
  input  logic [15:0]      p_in,
  input  logic             p_last,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] acc_cnt,
  output logic             acc_ovf,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e state_q, state_d;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] res_sum_q, res_sum_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic             res_ovf_q, res_ovf_d;
  logic             res_valid_q, res_valid_d;
  logic             overrun_q, overrun_d;

  logic [ACC_W-1:0] base_acc, sum_acc;
  logic [CNT_W-1:0] base_cnt, sum_cnt;
  logic             base_ovf, sum_ovf;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic             publish, accept;

  // The first beat of a vector starts from zero regardless of stale working regs.
  always_comb begin
    base_acc = (state_q == StAccum) ? acc_q : '0;
    base_cnt = (state_q == StAccum) ? cnt_q : '0;
    base_ovf = (state_q == StAccum) ? ovf_q : 1'b0;
    sum_ext  = {1'b0, base_acc} + {{(ACC_W + 1 - 16){1'b0}}, p_in};
    carry    = sum_ext[ACC_W];
`ifdef MAC_SAT_EN
    sum_acc  = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    sum_acc  = sum_ext[ACC_W-1:0];
`endif
    sum_cnt  = (base_cnt == {CNT_W{1'b1}}) ? base_cnt
                                           : base_cnt + {{(CNT_W - 1){1'b0}}, 1'b1};
    sum_ovf  = base_ovf | carry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (p_valid && !p_last) state_d = StAccum;
      StAccum: if (p_valid && p_last)  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StAccum);
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (p_valid) begin
      if (p_last) begin
        acc_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end else begin
        acc_d = sum_acc;
        cnt_d = sum_cnt;
        ovf_d = sum_ovf;
      end
    end
  end

  // One-deep result slot: a publish into an unconsumed slot is dropped and flagged.
  always_comb begin
    publish     = p_valid && p_last;
    accept      = res_valid_q && acc_ready;
    res_sum_d   = res_sum_q;
    res_cnt_d   = res_cnt_q;
    res_ovf_d   = res_ovf_q;
    res_valid_d = res_valid_q;
    overrun_d   = overrun_q;
    if (publish && (!res_valid_q || acc_ready)) begin
      res_sum_d   = sum_acc;
      res_cnt_d   = sum_cnt;
      res_ovf_d   = sum_ovf;
      res_valid_d = 1'b1;
    end else if (publish) begin
      overrun_d   = 1'b1;
    end else if (accept) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      res_sum_q   <= '0;
      res_cnt_q   <= '0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      res_sum_q   <= res_sum_d;
      res_cnt_q   <= res_cnt_d;
      res_ovf_q   <= res_ovf_d;
      res_valid_q <= res_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign acc_out   = res_sum_q;
  assign acc_cnt   = res_cnt_q;
  assign acc_ovf   = res_ovf_q;
  assign acc_valid = res_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: vector sums are computed from whole product lists and
// checked by a negedge monitor against the output slot.
module tb_mac_accumulator;

  localparam int unsigned AW   = 17;
  localparam int unsigned CW   = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          p_valid;
  logic [15:0]   p_in;
  logic          p_last;
  logic [AW-1:0] acc_out;
  logic [CW-1:0] acc_cnt;
  logic          acc_ovf;
  logic          acc_valid;
  logic          acc_ready;
  logic          overrun;
  logic          busy;

  mac_accumulator #(.ACC_W(AW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .p_valid   (p_valid),
    .p_in      (p_in),
    .p_last    (p_last),
    .acc_out   (acc_out),
    .acc_cnt   (acc_cnt),
    .acc_ovf   (acc_ovf),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .overrun   (overrun),
    .busy      (busy)
  );

  typedef struct {
    logic [AW-1:0] sum;
    logic [CW-1:0] cnt;
    logic          ovf;
  } res_t;

  int unsigned vec_q[$];   // products of the vector in flight
  res_t        exp_q[$];   // results expected to appear at the output slot
  bit          slot_full;
  bit          exp_ovr;
  int          checks;
  int          errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t model_result();
    res_t    r;
    longint  total;
    longint  limit;
    total = 0;
    foreach (vec_q[i]) total += longint'(vec_q[i]);
    limit = longint'(1) << AW;
    r.ovf = (total >= limit);
    r.cnt = (vec_q.size() > CMAX) ? CW'(CMAX) : CW'(vec_q.size());
`ifdef MAC_SAT_EN
    r.sum = r.ovf ? {AW{1'b1}} : AW'(total);
`else
    r.sum = AW'(total % limit);
`endif
    return r;
  endfunction

  // Drive one cycle of stimulus, then advance the reference model at the edge.
  task automatic beat(input bit v, input int unsigned d, input bit l, input bit rdy);
    res_t r;
    p_valid   = v;
    p_in      = d[15:0];
    p_last    = l;
    acc_ready = rdy;
    @(posedge clk);
    if (slot_full && rdy) slot_full = 1'b0;
    if (v) begin
      vec_q.push_back(d & 32'hffff);
      if (l) begin
        r = model_result();
        vec_q.delete();
        if (!slot_full) begin
          exp_q.push_back(r);
          slot_full = 1'b1;
        end else begin
          exp_ovr = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    p_valid   = 1'b0;
    p_in      = '0;
    p_last    = 1'b0;
    acc_ready = 1'b0;
    rst       = 1'b1;
    #1;
    chk("rst_acc_out", 32'(acc_out), 0);
    chk("rst_acc_cnt", 32'(acc_cnt), 0);
    chk("rst_acc_ovf", 32'(acc_ovf), 0);
    chk("rst_acc_valid", 32'(acc_valid), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_busy", 32'(busy), 0);
    vec_q.delete();
    exp_q.delete();
    slot_full = 1'b0;
    exp_ovr   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("acc_valid", 32'(acc_valid), 32'(slot_full));
      chk("overrun", 32'(overrun), 32'(exp_ovr));
      chk("busy", 32'(busy), 32'(vec_q.size() != 0));
      if (acc_valid) begin
        if (exp_q.size() == 0) begin
          chk("result_pending", 0, 1);
        end else begin
          chk("acc_out", 32'(acc_out), 32'(exp_q[0].sum));
          chk("acc_cnt", 32'(acc_cnt), 32'(exp_q[0].cnt));
          chk("acc_ovf", 32'(acc_ovf), 32'(exp_q[0].ovf));
          if (acc_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    slot_full = 1'b0;
    exp_ovr   = 1'b0;
    do_reset();

    // Three-beat vector with downstream always ready.
    beat(1, 10, 0, 1);
    beat(1, 20, 0, 1);
    beat(1, 30, 1, 1);
    repeat (2) beat(0, 0, 0, 1);

    // Single-beat vector straight from idle.
    beat(1, 65025, 1, 1);
    repeat (2) beat(0, 0, 0, 1);

    // Sum exceeds the 17-bit accumulator.
    beat(1, 65025, 0, 1);
    beat(1, 65025, 0, 1);
    beat(1, 65025, 1, 1);
    repeat (2) beat(0, 0, 0, 1);

    // Second result arrives while the first is still held.
    beat(1, 5, 1, 0);
    beat(1, 7, 0, 0);
    beat(1, 8, 1, 0);
    repeat (2) beat(0, 0, 0, 0);
    repeat (2) beat(0, 0, 0, 1);

    // Gaps inside a vector, then publish in the same cycle as acceptance.
    beat(1, 1, 0, 0);
    repeat (3) beat(0, 0, 0, 0);
    beat(1, 2, 1, 0);
    beat(0, 0, 0, 0);
    beat(1, 4, 1, 1);
    repeat (2) beat(0, 0, 0, 1);

    // Long vector saturates the beat counter.
    for (int i = 0; i < 20; i++) beat(1, 1, (i == 19), 1);
    repeat (2) beat(0, 0, 0, 1);

    // Reset in the middle of a vector discards the partial sum.
    beat(1, 100, 0, 1);
    beat(1, 200, 0, 1);
    do_reset();
    beat(1, 9, 1, 1);
    repeat (2) beat(0, 0, 0, 1);

    for (int i = 0; i < 600; i++) begin
      bit          v;
      int unsigned d;
      v = ($urandom_range(0, 1) == 1);
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(60000, 65535) : $urandom_range(0, 65535);
      beat(v, d, v && ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
    end

    beat(1, 3, 1, 1);
    repeat (4) beat(0, 0, 0, 1);
    chk("drain_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Downstream consumer of the 8x8 pipelined Wallace-tree multiplier's 16-bit product.
- Sums a vector of products into an ACC_W-bit dot-product result, terminated by a last flag.
- Holds each finished result in an output register with a valid/ready handshake, so the next vector can accumulate while the previous result waits.
- Flags per-vector overflow and sticky result overrun.

Parameters:
- ACC_W, 24, accumulator and result width; must be >= 17.
- CNT_W, 8, width of the beat counter reported with each result.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous active-high reset
- p_valid  input  1  p_in holds a valid product this cycle (multiplier enable delayed by its 2-cycle latency)
- p_in  input  16  unsigned product from multiplier
- p_last  input  1  qualified by p_valid; marks final product of a vector
- acc_out  output  ACC_W  finished vector sum
- acc_cnt  output  CNT_W  number of products in the finished vector
- acc_ovf  output  1  overflow occurred in the finished vector
- acc_valid  output  1  acc_out, acc_cnt and acc_ovf are valid
- acc_ready  input  1  downstream accepts the result when acc_valid && acc_ready
- overrun  output  1  sticky: a finished result was lost
- busy  output  1  high while in ACCUM

Behaviour:
- Reset (async, immediate): state=IDLE; acc, cnt, ovf working regs=0; acc_out=0, acc_cnt=0, acc_ovf=0, acc_valid=0, overrun=0, busy=0.
- Product zero-extended to ACC_W before add. Beat counter saturates at 2^CNT_W-1.
- FSM states: IDLE, ACCUM. busy = (state==ACCUM).
- IDLE, p_valid && !p_last: acc<=p_in, cnt<=1, ovf<=0; go to ACCUM.
- IDLE, p_valid && p_last: single-beat vector; publish sum=p_in, cnt=1, ovf=0; stay IDLE.
- ACCUM, p_valid && !p_last: acc<=acc+p_in, cnt<=cnt+1, ovf<=ovf|carry_out.
- ACCUM, p_valid && p_last: publish sum=acc+p_in, cnt=cnt+1, ovf=ovf|carry; clear working regs; go to IDLE.
- No p_valid: hold everything; gaps of any length inside a vector are legal.
- Publish = load acc_out/acc_cnt/acc_ovf and set acc_valid=1 on the next edge. Result is visible 1 cycle after the p_last beat.
- Handshake: acc_valid falls the cycle after acc_valid && acc_ready, unless a publish occurs in that same cycle, in which case acc_valid stays 1 with the new data.
- Overrun: publish while acc_valid && !acc_ready keeps the old result, drops the new one and sets overrun=1. overrun clears only on rst.
- The block never stalls the multiplier; p_valid is always accepted.
- Carry_out = bit ACC_W of the (ACC_W+1)-bit sum. Without saturation the sum wraps modulo 2^ACC_W.
- Reset mid-vector discards the partial sum with no publish.

Optional Feature:
- Macro MAC_SAT_EN.
- Defined: on carry_out the accumulator clamps to 2^ACC_W-1 and stays clamped for the rest of the vector; acc_ovf is still reported.
- Undefined: wrap-around as above.

Test Plan:
- Reset, then vector 10,20,30 (last on 30), acc_ready=1 -> one cycle after the last beat: acc_out=60, acc_cnt=3, acc_ovf=0, acc_valid=1 for exactly 1 cycle.
- Single beat 65025 with p_last, from IDLE -> acc_out=65025, acc_cnt=1, busy never asserted.
- ACC_W=17: vector 65025,65025,65025 -> wrap build gives acc_out=64003 (195075 mod 131072), acc_ovf=1; MAC_SAT_EN build gives acc_out=131071, acc_ovf=1.
- acc_ready=0: vector {5} then vector {7,8} -> acc_out stays 5, overrun=1; raise acc_ready -> 5 consumed, acc_valid=0, overrun stays 1.
- Vector 1,2 with 3 idle cycles between beats, then a new vector 4 whose publish coincides with acceptance of the prior result -> acc_out=3 accepted, then acc_out=4 with acc_valid held high continuously.
- Assert rst mid-vector after beats 100,200; then vector {9} -> acc_out=9, acc_cnt=1; all outputs 0 during reset.
